// File: rtl/buf_inst_sequencer.sv
// buf_inst_sequencer: expands one matrix-vector command into per-row BUF_READs and per-result BUF_WRITEs.
// Define BUF_SEQ_ERR_CHECK_EN to enable sticky protocol-error detection on err.
`ifndef BUF_READ
`define BUF_READ 2'b01
`endif
`ifndef BUF_WRITE
`define BUF_WRITE 2'b10
`endif

module buf_inst_sequencer #(
    parameter int OFFSET_W = 8,
    parameter int MEMB_W   = 8,
    parameter int MODE_W   = 2,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNT_W-1:0]    cmd_rows,
    input  logic [OFFSET_W-1:0] cmd_mema_base,
    input  logic [MEMB_W-1:0]   cmd_memb_base,
    input  logic [OFFSET_W-1:0] cmd_out_base,
    input  logic [MODE_W-1:0]   cmd_mode,
    output logic                buf_inst_valid,
    output logic [1:0]          buf_inst_opcode,
    output logic [OFFSET_W-1:0] buf_inst_mema_offset,
    output logic [MEMB_W-1:0]   buf_inst_memb_offset,
    output logic [MODE_W-1:0]   buf_inst_mode,
    output logic                pe_in_valid,
    input  logic                pe_result_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

    logic [1:0]          state, state_nx;
    logic [CNT_W-1:0]    n_q, rd_cnt, wr_cnt;
    logic [OFFSET_W-1:0] rd_mema, wr_addr;
    logic [MEMB_W-1:0]   rd_memb;
    logic [MODE_W-1:0]   mode_q;
    logic [1:0]          pipe;
    logic                accept, active, rd_pend, wr_now, rd_issue;

    assign cmd_ready = state == S_IDLE;
    assign busy      = !cmd_ready;
    assign done      = state == S_DONE;
    assign accept    = cmd_valid && cmd_ready;
    assign active    = state == S_RUN || state == S_DRAIN;
    // A pending READ yields its slot to a same-cycle WRITE and stays pending
    assign wr_now    = active && pe_result_valid && wr_cnt != n_q;
    assign rd_pend   = state == S_RUN && rd_cnt != n_q;
    assign rd_issue  = rd_pend && !wr_now;

    assign buf_inst_valid       = wr_now || rd_pend;
    assign buf_inst_opcode      = wr_now ? `BUF_WRITE : rd_pend ? `BUF_READ : 2'b00;
    assign buf_inst_mema_offset = wr_now ? wr_addr : rd_pend ? rd_mema : '0;
    assign buf_inst_memb_offset = rd_issue ? rd_memb : '0;
    assign buf_inst_mode        = rd_issue ? mode_q : '0;
    assign pe_in_valid          = pipe[1];

    always_comb begin
        state_nx = state == S_IDLE  ? (accept ? (cmd_rows == '0 ? S_DONE : S_RUN) : S_IDLE) :
                   state == S_RUN   ? (rd_cnt == n_q ? S_DRAIN : S_RUN) :
                   state == S_DRAIN ? (wr_cnt == n_q ? S_DONE : S_DRAIN) : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            n_q     <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            rd_mema <= '0;
            rd_memb <= '0;
            wr_addr <= '0;
            mode_q  <= '0;
            pipe    <= '0;
        end else begin
            state <= state_nx;
            pipe  <= {pipe[0], rd_issue};
            if (accept) begin
                n_q     <= cmd_rows;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
                rd_mema <= cmd_mema_base;
                rd_memb <= cmd_memb_base;
                wr_addr <= cmd_out_base;
                mode_q  <= cmd_mode;
            end else begin
                if (rd_issue) begin
                    rd_cnt  <= rd_cnt + CNT_W'(1);
                    rd_mema <= rd_mema + OFFSET_W'(1);
                    rd_memb <= rd_memb + MEMB_W'(1);
                end
                if (wr_now) begin
                    wr_cnt  <= wr_cnt + CNT_W'(1);
                    wr_addr <= wr_addr + OFFSET_W'(1);
                end
            end
        end
    end

`ifdef BUF_SEQ_ERR_CHECK_EN
    logic [CNT_W-1:0] pin_cnt;
    logic             err_q;

    assign err = err_q;

    // A result is legal only once its input pulse has already reached the PE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            pin_cnt <= accept ? '0 : pin_cnt + CNT_W'(pe_in_valid);
            if ((pe_result_valid && !wr_now) || (wr_now && wr_cnt >= pin_cnt))
                err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_buf_inst_sequencer.sv
// tb_buf_inst_sequencer: scoreboard bench for buf_inst_sequencer.
`timescale 1ns/1ps
`ifndef BUF_READ
`define BUF_READ 2'b01
`endif
`ifndef BUF_WRITE
`define BUF_WRITE 2'b10
`endif

module tb_buf_inst_sequencer;
`ifdef BUF_SEQ_ERR_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [7:0] cmd_rows = '0, cmd_mema_base = '0, cmd_memb_base = '0, cmd_out_base = '0;
    logic [1:0] cmd_mode = '0;
    logic       buf_inst_valid;
    logic [1:0] buf_inst_opcode;
    logic [7:0] buf_inst_mema_offset, buf_inst_memb_offset;
    logic [1:0] buf_inst_mode;
    logic       pe_in_valid, pe_result_valid = 1'b0, busy, done, err;

    buf_inst_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
        .cmd_mema_base(cmd_mema_base), .cmd_memb_base(cmd_memb_base),
        .cmd_out_base(cmd_out_base), .cmd_mode(cmd_mode),
        .buf_inst_valid(buf_inst_valid), .buf_inst_opcode(buf_inst_opcode),
        .buf_inst_mema_offset(buf_inst_mema_offset), .buf_inst_memb_offset(buf_inst_memb_offset),
        .buf_inst_mode(buf_inst_mode), .pe_in_valid(pe_in_valid),
        .pe_result_valid(pe_result_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] mema; logic [7:0] memb; logic [1:0] mode; } rd_t;
    rd_t        exp_rd[$];
    logic [7:0] exp_wr[$];
    rd_t        e_rd;
    logic [7:0] e_wr;
    bit         rd_hist[0:4095];
    bit         due[0:4095];
    bit         mon_en = 0, auto_pe = 0, manual_res = 0;
    int         cyc = 0, n_cmp = 0, n_err = 0, done_cnt = 0, inst_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // PE stand-in: a result arrives 3 cycles after each input pulse
    always @(posedge clk) begin
        #2;
        pe_result_valid = manual_res | (auto_pe & due[cyc]);
    end

    always @(negedge clk) if (mon_en) begin
        if (done) done_cnt++;
        if (buf_inst_valid) begin
            inst_cnt++;
            n_cmp++;
            if (buf_inst_opcode == `BUF_READ) begin
                rd_hist[cyc] = 1;
                if (exp_rd.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected cyc=%0d: got READ mema=%h, required no READ", cyc, buf_inst_mema_offset);
                end else begin
                    e_rd = exp_rd.pop_front();
                    if ({buf_inst_mema_offset, buf_inst_memb_offset, buf_inst_mode} !== e_rd) begin
                        n_err++;
                        $display("FAIL rd_fields cyc=%0d: got mema=%h memb=%h mode=%h, required mema=%h memb=%h mode=%h",
                                 cyc, buf_inst_mema_offset, buf_inst_memb_offset, buf_inst_mode, e_rd.mema, e_rd.memb, e_rd.mode);
                    end
                end
            end else if (buf_inst_opcode == `BUF_WRITE) begin
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected cyc=%0d: got WRITE mema=%h, required no WRITE", cyc, buf_inst_mema_offset);
                end else begin
                    e_wr = exp_wr.pop_front();
                    if ({buf_inst_mema_offset, buf_inst_memb_offset, buf_inst_mode} !== {e_wr, 8'h00, 2'b00}) begin
                        n_err++;
                        $display("FAIL wr_fields cyc=%0d: got mema=%h memb=%h mode=%h, required mema=%h memb=00 mode=0",
                                 cyc, buf_inst_mema_offset, buf_inst_memb_offset, buf_inst_mode, e_wr);
                    end
                end
            end else begin
                n_err++;
                $display("FAIL opcode cyc=%0d: got %b, required READ or WRITE", cyc, buf_inst_opcode);
            end
        end
        n_cmp++;
        if (pe_in_valid !== (cyc >= 2 && rd_hist[cyc-2])) begin
            n_err++;
            $display("FAIL pe_in_valid cyc=%0d: got %b, required %b", cyc, pe_in_valid, cyc >= 2 && rd_hist[cyc-2]);
        end
        if (pe_in_valid && auto_pe) due[cyc+3] = 1;
    end

    task automatic start_cmd(input logic [7:0] n, input logic [7:0] ma, input logic [7:0] mb,
                             input logic [7:0] ob, input logic [1:0] md);
        logic [7:0] k;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_ready_idle: got %b, required 1", cmd_ready);
        end
        for (int i = 0; i < n; i++) begin
            k = 8'(i);
            exp_rd.push_back('{mema: ma + k, memb: mb + k, mode: md});
            exp_wr.push_back(ob + k);
        end
        cmd_rows = n; cmd_mema_base = ma; cmd_memb_base = mb; cmd_out_base = ob; cmd_mode = md;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen = 0;
        int d0 = done_cnt;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done_timeout: done=0 after %0d cycles, required 1", nm, budget);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL %s_done_pulses: got %0d, required 1", nm, done_cnt - d0);
        end
        n_cmp++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL %s_leftover: got %0d reads %0d writes outstanding, required 0/0", nm, exp_rd.size(), exp_wr.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cmd_ready, busy, buf_inst_valid, pe_in_valid, done, err} !== 6'b100000) begin
                n_err++;
                $display("FAIL reset_state: got rdy/busy/vld/pin/done/err=%b, required 100000",
                         {cmd_ready, busy, buf_inst_valid, pe_in_valid, done, err});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        auto_pe = 1;
        start_cmd(8'd3, 8'h10, 8'h20, 8'h40, 2'd2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        wait_done(60, "basic");
        auto_pe = 0;
    endtask

    task automatic test_collision;
        start_cmd(8'd3, 8'h30, 8'h50, 8'h60, 2'd1);
        @(posedge clk); #1;
        manual_res = 1;
        @(negedge clk);
        n_cmp++;
        if ({buf_inst_valid, buf_inst_opcode, buf_inst_mema_offset} !== {1'b1, `BUF_WRITE, 8'h60}) begin
            n_err++;
            $display("FAIL coll_write: got vld=%b op=%b mema=%h, required 1/WRITE/60",
                     buf_inst_valid, buf_inst_opcode, buf_inst_mema_offset);
        end
        @(posedge clk); #1;
        manual_res = 0;
        @(negedge clk);
        n_cmp++;
        if ({buf_inst_opcode, buf_inst_mema_offset, buf_inst_memb_offset} !== {`BUF_READ, 8'h31, 8'h51}) begin
            n_err++;
            $display("FAIL coll_reread: got op=%b mema=%h memb=%h, required READ/31/51",
                     buf_inst_opcode, buf_inst_mema_offset, buf_inst_memb_offset);
        end
        repeat (5) @(posedge clk);
        #1 manual_res = 1;
        repeat (2) @(posedge clk);
        #1 manual_res = 0;
        wait_done(20, "coll");
    endtask

    task automatic test_zero;
        int i0 = inst_cnt;
        start_cmd(8'd0, 8'h77, 8'h77, 8'h77, 2'd3);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_done_lat: got done=%b in cycle after accept, required 1", done);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL zero_back_idle: got done/rdy=%b, required 01", {done, cmd_ready});
        end
        n_cmp++;
        if (inst_cnt !== i0) begin
            n_err++;
            $display("FAIL zero_no_inst: got %0d instructions, required 0", inst_cnt - i0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        auto_pe = 1;
        start_cmd(8'd3, 8'hFE, 8'hFF, 8'hFF, 2'd0);
        wait_done(60, "wrap");
        auto_pe = 0;
    endtask

    task automatic test_stray_err;
        manual_res = 1;
        @(negedge clk);
        n_cmp++;
        if (buf_inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_no_write: got vld=%b, required 0", buf_inst_valid);
        end
        @(posedge clk); #1;
        manual_res = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (err !== EXP_ERR) begin
                n_err++;
                $display("FAIL stray_err: got %b, required %b", err, EXP_ERR);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        auto_pe = 1;
        start_cmd(8'd4, 8'h80, 8'h90, 8'hA0, 2'd2);
        @(negedge clk);
        mon_en = 0;
        rst_n = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        auto_pe = 0;
        foreach (due[i]) due[i] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cmd_ready, busy, buf_inst_valid, pe_in_valid, done, err} !== 6'b100000) begin
                n_err++;
                $display("FAIL abort_state: got rdy/busy/vld/pin/done/err=%b, required 100000",
                         {cmd_ready, busy, buf_inst_valid, pe_in_valid, done, err});
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, buf_inst_valid, pe_in_valid, done} !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_quiet: got busy/vld/pin/done=%b, required 0000",
                         {busy, buf_inst_valid, pe_in_valid, done});
            end
        end
        mon_en = 1;
        @(posedge clk); #1;
        auto_pe = 1;
        start_cmd(8'd2, 8'h05, 8'h06, 8'h07, 2'd1);
        wait_done(60, "after_abort");
        auto_pe = 0;
    endtask

    initial begin
        test_reset;
        mon_en = 1;
        test_basic;
        test_collision;
        test_zero;
        test_wrap;
        test_stray_err;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
